idct_col_mac: RTL

Parametrised, fully pipelined multiply-accumulate tile for the HEVC inverse transform. Each tile computes one output sample of an N-point 1-D IDCT: the dot product of N input coefficients with one column of the HEVC integer transform matrix, followed by rounding, shifting and saturation. Tiles are daisy-chained through a registered copy of the input vector. One tile per output column fills an N-wide row/column IDCT stage, with one sample per cycle throughput.

---
 rtl/idct_col_mac_if.sv | 28 ++
 rtl/idct_col_mac.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/idct_col_mac_if.sv
// Port bundle of one HEVC IDCT column MAC tile: sample input, result output and the
// registered daisy-chain copy of the input vector for the next tile.
interface idct_col_mac_if #(
    parameter int N  = 8,
    parameter int DW = 25,
    parameter int OW = 16
);
    logic                 ce;
    logic                 in_valid;
    logic [3:0]           shift;
    logic [N*DW-1:0]      d_in;
    logic                 out_valid;
    logic signed [OW-1:0] d_out;
    logic                 sat;
    logic                 prop_valid;
    logic [N*DW-1:0]      d_prop;

    // Valid-only flow: in_valid qualifies d_in/shift on ce=1 edges, out_valid qualifies
    // d_out/sat (consumer also qualifies with ce); there is no ready, every result must be taken.
    modport master (
        output ce, in_valid, shift, d_in,
        input  out_valid, d_out, sat, prop_valid, d_prop
    );
    modport slave (
        input  ce, in_valid, shift, d_in,
        output out_valid, d_out, sat, prop_valid, d_prop
    );
endinterface

// File: rtl/idct_col_mac.sv
// One output column of an N-point HEVC 1-D IDCT: N-stage pipelined dot product with
// constant transform coefficients, then round, arithmetic shift and saturate.
module idct_col_mac #(
    parameter int N   = 8,
    parameter int COL = 1,
    parameter int DW  = 25,
    parameter int OW  = 16,
    parameter int AW  = DW + 12
) (
    input  logic          clk,
    input  logic          reset,
    idct_col_mac_if.slave bus
);

    // Magnitude of the 32-point basis at angle j*pi/64 (j=0 is the DC row value).
    function automatic int base_mag(input int j);
        int v;
        case (j)
            0:  v = 64;  1:  v = 90;  2:  v = 90;  3:  v = 90;
            4:  v = 89;  5:  v = 88;  6:  v = 87;  7:  v = 85;
            8:  v = 83;  9:  v = 82;  10: v = 80;  11: v = 78;
            12: v = 75;  13: v = 73;  14: v = 70;  15: v = 67;
            16: v = 64;  17: v = 61;  18: v = 57;  19: v = 54;
            20: v = 50;  21: v = 46;  22: v = 43;  23: v = 38;
            24: v = 36;  25: v = 31;  26: v = 25;  27: v = 22;
            28: v = 18;  29: v = 13;  30: v = 9;   31: v = 4;
            default: v = 0;
        endcase
        return v;
    endfunction

    // T32[k][n] follows cos(k*(2n+1)*pi/64); fold the angle into the first quadrant.
    function automatic int t32(input int k, input int n);
        int m;
        int v;
        m = (k * (2 * n + 1)) % 128;
        if (m > 64) m = 128 - m;
        if (m > 32) v = -base_mag(64 - m);
        else        v = base_mag(m);
        return v;
    endfunction

    function automatic logic [N*8-1:0] build_coefs();
        logic [N*8-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*8 +: 8] = 8'(t32(i * (32 / N), COL));
        return v;
    endfunction

    localparam logic [N*8-1:0]       COEFS   = build_coefs();
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic [N-1:0]         r_vld;
    logic signed [AW-1:0] r_acc [N];
    logic [3:0]           r_sh  [N];

    logic [N-1:0]         w_vin;
    logic signed [AW-1:0] w_acc_in [N];
    logic [3:0]           w_sh_in  [N];
    logic signed [AW-1:0] w_prod   [N];
    logic signed [DW-1:0] w_x      [N];

    // Valid entering stage s: in_valid for stage 0, else the previous stage's valid.
    assign w_vin       = {r_vld[N-2:0], bus.in_valid};
    assign w_acc_in[0] = '0;
    assign w_sh_in[0]  = bus.shift;
    assign w_x[0]      = bus.d_in[DW-1:0];

    for (genvar s = 1; s < N; s++) begin : g_link
        assign w_acc_in[s] = r_acc[s-1];
        assign w_sh_in[s]  = r_sh[s-1];
    end

    for (genvar s = 0; s < N; s++) begin : g_prod
        assign w_prod[s] = AW'(w_x[s]) * AW'($signed(COEFS[s*8 +: 8]));
    end

    // Lane k waits k registers so it reaches stage k together with its accumulator.
    for (genvar k = 1; k < N; k++) begin : g_lane
        logic [DW-1:0] r_dl [k];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int j = 0; j < k; j++) r_dl[j] <= '0;
            end else if (bus.ce) begin
                if (bus.in_valid) r_dl[0] <= bus.d_in[k*DW +: DW];
                for (int j = 1; j < k; j++) begin
                    if (r_vld[j-1]) r_dl[j] <= r_dl[j-1];
                end
            end
        end

        assign w_x[k] = r_dl[k-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            for (int s = 0; s < N; s++) begin
                r_acc[s] <= '0;
                r_sh[s]  <= '0;
            end
        end else if (bus.ce) begin
            r_vld <= w_vin;
            for (int s = 0; s < N; s++) begin
                if (w_vin[s]) begin
                    r_acc[s] <= w_acc_in[s] + w_prod[s];
                    r_sh[s]  <= w_sh_in[s];
                end
            end
        end
    end

    logic signed [AW-1:0] w_rnd;
    logic signed [AW-1:0] w_r;
    logic signed [OW-1:0] w_res;
    logic                 w_sat;

    always_comb begin
        w_rnd = '0;
        if (r_sh[N-1] != 4'd0) w_rnd = AW'(1) <<< (r_sh[N-1] - 4'd1);
        w_r   = (r_acc[N-1] + w_rnd) >>> r_sh[N-1];
        w_res = w_r[OW-1:0];
        w_sat = 1'b0;
        if (w_r > SAT_MAX) begin
            w_res = SAT_MAX[OW-1:0];
            w_sat = 1'b1;
        end else if (w_r < SAT_MIN) begin
            w_res = SAT_MIN[OW-1:0];
            w_sat = 1'b1;
        end
    end

    logic                 r_out_valid;
    logic signed [OW-1:0] r_d_out;
    logic                 r_sat;
    logic                 r_prop_valid;
    logic [N*DW-1:0]      r_d_prop;

    // d_out/sat hold the last result while out_valid is low; d_prop copies d_in regardless of valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_d_out      <= '0;
            r_sat        <= 1'b0;
            r_prop_valid <= 1'b0;
            r_d_prop     <= '0;
        end else if (bus.ce) begin
            r_out_valid  <= r_vld[N-1];
            r_prop_valid <= bus.in_valid;
            r_d_prop     <= bus.d_in;
            if (r_vld[N-1]) begin
                r_d_out <= w_res;
                r_sat   <= w_sat;
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.d_out      = r_d_out;
    assign bus.sat        = r_sat;
    assign bus.prop_valid = r_prop_valid;
    assign bus.d_prop     = r_d_prop;

endmodule
